// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC sequencer issuing instruction-fetch requests over valid/ready,
// with branch redirects and a sticky misalignment trap. Rev 1.0
`default_nettype none

module pc_fetch_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     INCR         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] pc_plus_incr,
  output logic            misalign_err,
  output logic [XLEN-1:0] err_addr
);

  localparam logic [XLEN-1:0] INCR_W = XLEN'(INCR);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic [XLEN-1:0] err_addr_nxt;
  logic            pend, pend_nxt;
  logic            valid_nxt;
  logic            err_nxt;
  logic            fire;
  logic            misaligned;

  assign fire         = fetch_valid & fetch_ready;
  assign misaligned   = redirect_valid & (redirect_target[1:0] != 2'b00);
  assign fetch_addr   = pc;
  assign pc_plus_incr = pc + INCR_W;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_nxt        = pend;
    pend_target_nxt = pend_target;
    valid_nxt       = fetch_valid;
    err_nxt         = misalign_err;
    err_addr_nxt    = err_addr;

    case (state)
      BOOT, RUN: begin
        if (misaligned) begin
          // Trap wins over everything; any outstanding request is dropped.
          state_nxt    = ERR;
          valid_nxt    = 1'b0;
          err_nxt      = 1'b1;
          err_addr_nxt = redirect_target;
        end else begin
          state_nxt = RUN;
          valid_nxt = (fetch_valid & ~fire) ? 1'b1 : ~stall;
          if (redirect_valid && (!fetch_valid || fire)) begin
            pc_nxt   = redirect_target;
            pend_nxt = 1'b0;
          end else if (redirect_valid) begin
            // Request is held unaccepted: park the target until it fires.
            pend_nxt        = 1'b1;
            pend_target_nxt = redirect_target;
          end else if (fire && pend) begin
            pc_nxt   = pend_target;
            pend_nxt = 1'b0;
          end else if (fire) begin
            pc_nxt = pc + INCR_W;
          end
        end
      end
      ERR: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = ERR;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      pend         <= 1'b0;
      pend_target  <= '0;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      pend         <= pend_nxt;
      pend_target  <= pend_target_nxt;
      fetch_valid  <= valid_nxt;
      misalign_err <= err_nxt;
      err_addr     <= err_addr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed test of pc_fetch_sequencer against a behavioural model.
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_ready = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [31:0] pc_plus_incr;
  logic        misalign_err;
  logic [31:0] err_addr;

  logic        rst2 = 1'b1;
  logic        fetch_valid2;
  logic [31:0] fetch_addr2;
  logic [31:0] pc_plus_incr2;
  logic        misalign_err2;
  logic [31:0] err_addr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .INCR(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .pc_plus_incr(pc_plus_incr),
    .misalign_err(misalign_err), .err_addr(err_addr)
  );

  pc_fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .INCR(4)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .fetch_valid(fetch_valid2), .fetch_ready(1'b1),
    .fetch_addr(fetch_addr2), .pc_plus_incr(pc_plus_incr2),
    .misalign_err(misalign_err2), .err_addr(err_addr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the request the sequencer should be presenting right now.
  logic        m_live = 1'b0;
  logic        m_trapped;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_has_pending;
  logic [31:0] m_pending;
  logic [31:0] m_err_addr;
  wire         m_accepted = m_req & fetch_ready;

  always @(posedge clk) begin
    if (rst) begin
      m_live        <= 1'b1;
      m_trapped     <= 1'b0;
      m_req         <= 1'b0;
      m_addr        <= 32'h0;
      m_has_pending <= 1'b0;
      m_pending     <= 32'h0;
      m_err_addr    <= 32'h0;
    end else if (m_live && !m_trapped) begin
      if (redirect_valid && (redirect_target % 4) != 0) begin
        m_trapped  <= 1'b1;
        m_err_addr <= redirect_target;
        m_req      <= 1'b0;
      end else begin
        m_req <= (m_req && !m_accepted) || !stall;
        if (redirect_valid && m_req && !m_accepted) begin
          m_has_pending <= 1'b1;
          m_pending     <= redirect_target;
        end else if (redirect_valid) begin
          m_addr        <= redirect_target;
          m_has_pending <= 1'b0;
        end else if (m_accepted) begin
          m_addr        <= m_has_pending ? m_pending : (m_addr + 32'd4) % 33'h1_0000_0000;
          m_has_pending <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model.fetch_valid", {31'b0, fetch_valid}, {31'b0, m_req});
      chk("model.fetch_addr", fetch_addr, m_addr);
      chk("model.pc_plus_incr", pc_plus_incr, m_addr + 32'd4);
      chk("model.misalign_err", {31'b0, misalign_err}, {31'b0, m_trapped});
      chk("model.err_addr", err_addr, m_err_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; fetch_ready = 1'b0;
    tick(2);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset.valid", {31'b0, fetch_valid}, 32'h0);
    chk("reset.addr", fetch_addr, 32'h0);
    chk("reset.err", {31'b0, misalign_err}, 32'h0);

    // Sequential fetch, one per cycle
    rst = 1'b0; fetch_ready = 1'b1;
    tick();
    chk("seq.valid", {31'b0, fetch_valid}, 32'h1);
    chk("seq.addr0", fetch_addr, 32'h0);
    chk("seq.plus0", pc_plus_incr, 32'h4);
    tick(); chk("seq.addr1", fetch_addr, 32'h4);
    tick(); chk("seq.addr2", fetch_addr, 32'h8);
    tick(); chk("seq.addr3", fetch_addr, 32'hC);
    chk("seq.plus3", pc_plus_incr, 32'h10);

    // Backpressure holds the request
    do_reset();
    rst = 1'b0; fetch_ready = 1'b1;
    tick(3);
    fetch_ready = 1'b0;
    tick(3);
    chk("bp.valid", {31'b0, fetch_valid}, 32'h1);
    chk("bp.addr", fetch_addr, 32'h8);
    fetch_ready = 1'b1;
    tick();
    chk("bp.next", fetch_addr, 32'hC);

    // Two redirects while a request is held; the latest one wins
    do_reset();
    rst = 1'b0; fetch_ready = 1'b1;
    tick(3);
    fetch_ready = 1'b0;
    redirect(32'h100);
    chk("redir.hold1", fetch_addr, 32'h8);
    redirect(32'h200);
    chk("redir.hold2", fetch_addr, 32'h8);
    fetch_ready = 1'b1;
    tick();
    chk("redir.target", fetch_addr, 32'h200);
    tick();
    chk("redir.next", fetch_addr, 32'h204);
    fetch_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid.valid", {31'b0, fetch_valid}, 32'h0);

    // Redirect captured under stall
    do_reset();
    stall = 1'b1; rst = 1'b0; fetch_ready = 1'b1;
    tick();
    chk("stall.boot_valid", {31'b0, fetch_valid}, 32'h0);
    redirect(32'h40);
    chk("stall.valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    chk("stall.still", {31'b0, fetch_valid}, 32'h0);
    stall = 1'b0;
    tick();
    chk("stall.release_valid", {31'b0, fetch_valid}, 32'h1);
    chk("stall.release_addr", fetch_addr, 32'h40);

    // Wrap-around instance
    rst2 = 1'b1; tick();
    rst2 = 1'b0; tick();
    chk("wrap.valid", {31'b0, fetch_valid2}, 32'h1);
    chk("wrap.addr0", fetch_addr2, 32'hFFFF_FFF8);
    tick(); chk("wrap.addr1", fetch_addr2, 32'hFFFF_FFFC);
    chk("wrap.plus1", pc_plus_incr2, 32'h0);
    tick(); chk("wrap.addr2", fetch_addr2, 32'h0);
    tick(); chk("wrap.addr3", fetch_addr2, 32'h4);
    chk("wrap.err", {31'b0, misalign_err2}, 32'h0);
    chk("wrap.err_addr", err_addr2, 32'h0);

    // Misaligned redirect traps
    do_reset();
    rst = 1'b0; fetch_ready = 1'b1;
    tick(2);
    redirect(32'h102);
    chk("mis.err", {31'b0, misalign_err}, 32'h1);
    chk("mis.err_addr", err_addr, 32'h102);
    chk("mis.valid", {31'b0, fetch_valid}, 32'h0);
    chk("mis.addr", fetch_addr, 32'h4);
    redirect(32'h300);
    tick(2);
    chk("mis.held_valid", {31'b0, fetch_valid}, 32'h0);
    chk("mis.held_addr", fetch_addr, 32'h4);
    chk("mis.held_err_addr", err_addr, 32'h102);
    rst = 1'b1;
    tick();
    chk("mis.rst_err", {31'b0, misalign_err}, 32'h0);
    chk("mis.rst_err_addr", err_addr, 32'h0);
    chk("mis.rst_addr", fetch_addr, 32'h0);
    rst = 1'b0;
    tick(2);
    chk("mis.recover", fetch_addr, 32'h4);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
